soundrive_dac: RTL and testbench

Four-channel 8-bit Soundrive/Covox mixer and first-order sigma-delta modulator. It sits directly downstream of the Z80 port decoder. It takes fclk-domain channel-write strobes and the port-FE beeper bit, and produces the 1-bit audio stream for the board `beep` pin. Channel writes are double-buffered and applied only on a fixed sample tick, so a partial multi-channel update never reaches the output.

---
 rtl/soundrive_dac.sv | 105 ++++++++++
 tb/tb_soundrive_dac.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/soundrive_dac.sv
// Four-channel Soundrive/Covox mixer: double-buffered channel writes applied on a
// fixed sample tick, serial 11-bit mix, first-order sigma-delta 1-bit output.
module soundrive_dac #(
    parameter int SAMPLE_DIV = 2048,
    parameter int BEEP_LVL   = 255
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        wr_stb,
    input  logic [1:0]  wr_ch,
    input  logic [7:0]  wr_data,
    input  logic        beep_in,
    input  logic        mute,
    output logic        tick,
    output logic [10:0] mix_out,
    output logic        dac_out
);
    localparam int          NUM_CH   = 4;
    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [10:0] BEEP_W   = 11'(BEEP_LVL);

    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4, S5} st_t;

    st_t                          st_q, st_d;
    logic [NUM_CH-1:0][7:0]       shadow_q;
    logic [NUM_CH-1:0][7:0]       active_q, active_d;
    logic [15:0]                  div_q, div_d;
    logic [10:0]                  acc_q, acc_d;
    logic [10:0]                  mix_q, mix_d;
    logic [10:0]                  sd_q, sd_d;
    logic                         beep_q, beep_d;
    logic                         dac_q, dac_d;
    logic [10:0]                  m;
    logic [11:0]                  sd_sum;

    // Shadow bank: CPU-visible, never feeds the mix until the next tick.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            shadow_q <= {NUM_CH{8'h80}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_stb && wr_ch == 2'(k)) shadow_q[k] <= wr_data;
            end
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? 16'd0 : div_q + 16'd1;

    always_comb begin
        st_d     = st_q;
        acc_d    = acc_q;
        mix_d    = mix_q;
        active_d = active_q;
        beep_d   = beep_q;
        case (st_q)
            IDLE: begin
                if (tick) begin
                    active_d = shadow_q;
                    beep_d   = beep_in;
                    acc_d    = '0;
                    st_d     = S0;
                end
            end
            S0: begin acc_d = acc_q + {3'b0, active_q[0]}; st_d = S1; end
            S1: begin acc_d = acc_q + {3'b0, active_q[1]}; st_d = S2; end
            S2: begin acc_d = acc_q + {3'b0, active_q[2]}; st_d = S3; end
            S3: begin acc_d = acc_q + {3'b0, active_q[3]}; st_d = S4; end
            S4: begin acc_d = acc_q + (beep_q ? BEEP_W : 11'd0); st_d = S5; end
            S5: begin mix_d = acc_q; st_d = IDLE; end
            default: st_d = IDLE;
        endcase
    end

    // Mute only gates the modulator input, so sd phase survives a mute window.
    assign m      = mute ? 11'd0 : mix_q;
    assign sd_sum = {1'b0, sd_q} + {1'b0, m};
    assign sd_d   = sd_sum[10:0];
    assign dac_d  = sd_sum[11];

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            st_q     <= IDLE;
            active_q <= {NUM_CH{8'h80}};
            div_q    <= '0;
            acc_q    <= '0;
            mix_q    <= '0;
            sd_q     <= '0;
            beep_q   <= 1'b0;
            dac_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            active_q <= active_d;
            div_q    <= div_d;
            acc_q    <= acc_d;
            mix_q    <= mix_d;
            sd_q     <= sd_d;
            beep_q   <= beep_d;
            dac_q    <= dac_d;
        end
    end

    assign mix_out = mix_q;
    assign dac_out = dac_q;
endmodule

// File: tb/tb_soundrive_dac.sv
// Directed bench for soundrive_dac with SAMPLE_DIV=8; outputs sampled on falling edges.
module tb_soundrive_dac;
    logic        fclk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_stb = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [7:0]  wr_data = '0;
    logic        beep_in = 1'b0;
    logic        mute = 1'b0;
    logic        tick;
    logic [10:0] mix_out;
    logic        dac_out;

    int errors = 0;
    int checks = 0;

    soundrive_dac #(.SAMPLE_DIV(8), .BEEP_LVL(255)) dut (
        .fclk(fclk), .rst(rst), .wr_stb(wr_stb), .wr_ch(wr_ch), .wr_data(wr_data),
        .beep_in(beep_in), .mute(mute), .tick(tick), .mix_out(mix_out), .dac_out(dac_out)
    );

    always #5 fclk = ~fclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        wr_stb = 1'b1; wr_ch = ch; wr_data = d;
        @(negedge fclk);
        wr_stb = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tick === 1'b1) begin ok = 1'b1; break; end
            @(negedge fclk);
        end
    endtask

    task automatic test_reset();
        logic        e_tick, e_dac;
        logic [10:0] e_mix;
        rst = 1'b1;
        repeat (3) @(negedge fclk);
        checks++; if (mix_out !== 11'd0) begin errors++; $display("FAIL rst_mix: got %0d want 0", mix_out); end
        checks++; if (dac_out !== 1'b0) begin errors++; $display("FAIL rst_dac: got %b want 0", dac_out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", tick); end
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            e_tick = (k % 8 == 7);
            e_mix  = (k >= 14) ? 11'd512 : 11'd0;
            e_dac  = (k >= 18) && ((k - 18) % 4 == 0);
            checks++; if (tick !== e_tick) begin errors++; $display("FAIL dflt_tick c%0d: got %b want %b", k, tick, e_tick); end
            checks++; if (mix_out !== e_mix) begin errors++; $display("FAIL dflt_mix c%0d: got %0d want %0d", k, mix_out, e_mix); end
            checks++; if (dac_out !== e_dac) begin errors++; $display("FAIL dflt_dac c%0d: got %b want %b", k, dac_out, e_dac); end
            @(negedge fclk);
        end
    endtask

    task automatic test_collision();
        bit ok;
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL coll_tick: no tick in 20 cycles, want one"); end
        wr(2'd2, 8'h00);
        repeat (6) @(negedge fclk);
        checks++; if (mix_out !== 11'd512) begin errors++; $display("FAIL coll_first: got %0d want 512", mix_out); end
        repeat (7) @(negedge fclk);
        checks++; if (mix_out !== 11'd512) begin errors++; $display("FAIL coll_hold: got %0d want 512", mix_out); end
        @(negedge fclk);
        checks++; if (mix_out !== 11'd384) begin errors++; $display("FAIL coll_next: got %0d want 384", mix_out); end
    endtask

    task automatic test_atomic();
        bit          ok;
        logic [10:0] e_mix;
        wr(2'd2, 8'h80);
        repeat (20) @(negedge fclk);
        checks++; if (mix_out !== 11'd512) begin errors++; $display("FAIL atom_pre: got %0d want 512", mix_out); end
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL atom_tick: no tick in 20 cycles, want one"); end
        for (int k = 1; k <= 20; k++) begin
            @(negedge fclk);
            e_mix = (k >= 15) ? 11'd160 : 11'd512;
            checks++; if (mix_out !== e_mix) begin errors++; $display("FAIL atom_mix +%0d: got %0d want %0d", k, mix_out, e_mix); end
            wr_stb  = (k == 1 || k == 3 || k == 5 || k == 7);
            wr_ch   = 2'((k - 1) / 2);
            wr_data = 8'(16 * ((k + 1) / 2));
        end
        wr_stb = 1'b0;
    endtask

    task automatic test_full_scale();
        int ones, bad;
        beep_in = 1'b1;
        for (int c = 0; c < 4; c++) wr(2'(c), 8'hFF);
        repeat (24) @(negedge fclk);
        checks++; if (mix_out !== 11'd1275) begin errors++; $display("FAIL full_mix: got %0d want 1275", mix_out); end
        ones = 0; bad = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge fclk);
            ones += int'(dac_out);
            if (mix_out !== 11'd1275) bad++;
        end
        checks++; if (ones != 1275) begin errors++; $display("FAIL full_density: got %0d ones want 1275", ones); end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_steady: %0d cycles off 1275, want 0", bad); end
    endtask

    task automatic test_mute();
        int ones, bad_dac, bad_mix;
        mute = 1'b1;
        bad_dac = 0; bad_mix = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge fclk);
            if (dac_out !== 1'b0) bad_dac++;
            if (mix_out !== 11'd1275) bad_mix++;
        end
        checks++; if (bad_dac != 0) begin errors++; $display("FAIL mute_dac: %0d high cycles, want 0", bad_dac); end
        checks++; if (bad_mix != 0) begin errors++; $display("FAIL mute_mix: %0d cycles off 1275, want 0", bad_mix); end
        mute = 1'b0;
        ones = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge fclk);
            ones += int'(dac_out);
        end
        checks++; if (ones != 1275) begin errors++; $display("FAIL mute_resume: got %0d ones want 1275", ones); end
    endtask

    task automatic test_mid_reset();
        bit          ok;
        logic        e_tick;
        logic [10:0] e_mix;
        logic [31:0] e_act;
        e_act = 32'h80808080;
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mrst_tick: no tick in 20 cycles, want one"); end
        repeat (3) @(negedge fclk);
        rst = 1'b1; beep_in = 1'b0;
        #1;
        checks++; if (mix_out !== 11'd0) begin errors++; $display("FAIL mrst_mix: got %0d want 0", mix_out); end
        checks++; if (dac_out !== 1'b0) begin errors++; $display("FAIL mrst_dac: got %b want 0", dac_out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mrst_tickval: got %b want 0", tick); end
        checks++; if (dut.active_q !== e_act) begin errors++; $display("FAIL mrst_active: got %h want %h", dut.active_q, e_act); end
        @(negedge fclk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e_tick = (k == 7 || k == 15);
            e_mix  = (k >= 14) ? 11'd512 : 11'd0;
            checks++; if (tick !== e_tick) begin errors++; $display("FAIL mrst_tick c%0d: got %b want %b", k, tick, e_tick); end
            checks++; if (mix_out !== e_mix) begin errors++; $display("FAIL mrst_mixrel c%0d: got %0d want %0d", k, mix_out, e_mix); end
            @(negedge fclk);
        end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_atomic();
        test_full_scale();
        test_mute();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
